// File: rtl/mem2_seq_reader.sv
// mem2_seq_reader: walks the RST pattern ROM from FIRST_ADDR to LAST_ADDR and
// streams each table bit out on a valid/ready handshake, counting zero bits
// and pulsing done_o once the last bit has been accepted.
// Optional build macro: MEM2_SEQ_REPEAT_EN -- when defined, playback loops
// continuously (DONE restarts at FIRST_ADDR) until abort_i or reset.
module mem2_seq_reader #(
    parameter int ADDR_W     = 10,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 21,
    parameter int CNT_W      = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              rst_bit_i,
    output logic              data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  zero_cnt_o
);

    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  ZERO_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic               data_q,  data_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [CNT_W-1:0]   zero_q,  zero_d;

    logic               hs;

    assign hs = valid_q && ready_i;

    // Next-state and next-output logic; abort overrides everything but reset.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        if (abort_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_d  = FIRST_A;
                        zero_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // addr_q has been on the ROM for a full cycle; capture it.
                    data_d  = rst_bit_i;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (hs) begin
                        valid_d = 1'b0;
                        if (!data_q && (zero_q != ZERO_MAX)) begin
                            zero_d = zero_q + CNT_W'(1);
                        end
                        if (addr_q == LAST_A) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
`ifdef MEM2_SEQ_REPEAT_EN
                    addr_d  = FIRST_A;
                    zero_d  = '0;
                    state_d = S_FETCH;
`else
                    state_d = S_IDLE;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign zero_cnt_o = zero_q;

endmodule

// File: tb/tb_mem2_seq_reader.sv
// Self-checking bench for mem2_seq_reader: directed scenarios plus randomized
// tables and backpressure, checked against a table-driven playback model.
module tb_mem2_seq_reader;

    localparam int FIRST = 1;
    localparam int LAST  = 21;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;

    // main instance
    logic       start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
    logic [9:0] addr_o;
    logic       rst_bit, data_o, valid_o, busy_o, done_o;
    logic [4:0] zero_cnt_o;

    // single-address instance
    logic       start6 = 1'b0, abort6 = 1'b0, ready6 = 1'b1;
    logic [9:0] addr6;
    logic       rst_bit6, data6, valid6, busy6, done6;
    logic [4:0] zero6;

    // saturation instance (2-bit counter, all-zero table)
    logic       start_s = 1'b0, abort_s = 1'b0, ready_s = 1'b1, zero_bit = 1'b0;
    logic [9:0] addr_s;
    logic       data_s, valid_s, busy_s, done_s;
    logic [1:0] zero_s;

    logic       tbl [0:1023];

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    assign rst_bit  = tbl[addr_o];
    assign rst_bit6 = tbl[addr6];

    mem2_seq_reader #(.ADDR_W(10), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .CNT_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .abort_i(abort_i),
        .addr_o(addr_o), .rst_bit_i(rst_bit), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o), .zero_cnt_o(zero_cnt_o));

    mem2_seq_reader #(.ADDR_W(10), .FIRST_ADDR(6), .LAST_ADDR(6), .CNT_W(5)) dut6 (
        .CLK(CLK), .RST_N(RST_N), .start_i(start6), .abort_i(abort6),
        .addr_o(addr6), .rst_bit_i(rst_bit6), .data_o(data6), .valid_o(valid6),
        .ready_i(ready6), .busy_o(busy6), .done_o(done6), .zero_cnt_o(zero6));

    mem2_seq_reader #(.ADDR_W(10), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .start_i(start_s), .abort_i(abort_s),
        .addr_o(addr_s), .rst_bit_i(zero_bit), .data_o(data_s), .valid_o(valid_s),
        .ready_i(ready_s), .busy_o(busy_s), .done_o(done_s), .zero_cnt_o(zero_s));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_default_table();
        for (int a = 0; a < 1024; a++) tbl[a] = 1'b1;
        tbl[0] = 1'b0;
        tbl[1] = 1'b0;
        tbl[6] = 1'b0;
    endtask

    // Hold ready high until the main DUT presents a bit at the target address.
    task automatic wait_emit(input int target);
        int n = 0;
        while (!(valid_o && addr_o == 10'(target)) && n < 200) begin
            ready_i = 1'b1;
            step();
            n++;
        end
        if (n >= 200) check("wait_emit_timeout", 32'd0, 32'd1);
    endtask

    // Full playback of the main DUT scored against the table contents.
    task automatic play(input int rdy_pct, input bit check_timing);
        int  exp_bits[$];
        int  exp_addr[$];
        int  zeros = 0;
        int  cyc;
        bit  seen_done = 0;
        for (int a = FIRST; a <= LAST; a++) begin
            exp_bits.push_back(int'(tbl[a]));
            exp_addr.push_back(a);
            if (!tbl[a]) zeros++;
        end
        if (zeros > 31) zeros = 31;
        start_i = 1'b1;
        ready_i = ($urandom_range(99) < rdy_pct);
        step();
        start_i = 1'b0;
        cyc = 1;
        check("play_busy_after_start", 32'(busy_o), 32'd1);
        while (!seen_done && cyc < 2000) begin
            if (done_o) begin
                seen_done = 1;
                check("play_all_bits_sent", 32'(exp_bits.size()), 32'd0);
                check("play_zero_cnt", 32'(zero_cnt_o), 32'(zeros));
                check("play_addr_at_done", 32'(addr_o), 32'(LAST));
                check("play_valid_at_done", 32'(valid_o), 32'd0);
                if (check_timing) check("play_done_cycle", 32'(cyc), 32'(2 * (LAST - FIRST + 1) + 1));
                $display("txn done cycles=%0d zero_cnt=%0d", cyc, zero_cnt_o);
            end else begin
                ready_i = ($urandom_range(99) < rdy_pct);
                if (valid_o && ready_i) begin
                    if (exp_bits.size() == 0) begin
                        check("play_extra_bit", 32'd1, 32'd0);
                    end else begin
                        check("play_bit", 32'(data_o), 32'(exp_bits.pop_front()));
                        check("play_addr", 32'(addr_o), 32'(exp_addr.pop_front()));
                    end
                    $display("txn addr=%0d bit=%0d", addr_o, data_o);
                end
                step();
                cyc++;
            end
        end
        if (!seen_done) check("play_done_timeout", 32'd0, 32'd1);
        step();
        check("play_done_one_cycle", 32'(done_o), 32'd0);
`ifdef MEM2_SEQ_REPEAT_EN
        check("play_repeat_busy", 32'(busy_o), 32'd1);
        check("play_repeat_addr", 32'(addr_o), 32'(FIRST));
        check("play_repeat_zero", 32'(zero_cnt_o), 32'd0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
`else
        check("play_busy_fall", 32'(busy_o), 32'd0);
`endif
        ready_i = 1'b0;
    endtask

    initial begin
        int n;
        load_default_table();

        // Reset state
        RST_N = 1'b0;
        step();
        step();
        check("rst_addr", 32'(addr_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_zero", 32'(zero_cnt_o), 32'd0);
        RST_N = 1'b1;
        step();

        // abort coincident with start in IDLE keeps the block idle
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_start_busy", 32'(busy_o), 32'd0);
        step();
        check("abort_start_valid", 32'(valid_o), 32'd0);

        // Full default playback, ready tied high
        play(100, 1'b1);

        // Backpressure at address 6
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_emit(6);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid_held", 32'(valid_o), 32'd1);
            check("bp_data_held", 32'(data_o), 32'd0);
            check("bp_addr_held", 32'(addr_o), 32'd6);
        end
        ready_i = 1'b1;
        step();
        check("bp_zero_cnt", 32'(zero_cnt_o), 32'd2);
        check("bp_valid_drop", 32'(valid_o), 32'd0);
        check("bp_addr_adv", 32'(addr_o), 32'd7);

        // Abort during a handshake at address 10
        wait_emit(10);
        ready_i = 1'b1;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_zero_kept", 32'(zero_cnt_o), 32'd2);
        check("abort_addr_kept", 32'(addr_o), 32'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", 32'(done_o), 32'd0);
        end

        // Restart after abort
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("restart_addr", 32'(addr_o), 32'(FIRST));
        check("restart_zero", 32'(zero_cnt_o), 32'd0);
        check("restart_busy", 32'(busy_o), 32'd1);

        // start ignored while busy, then reset mid-playback at address 4
        wait_emit(4);
        ready_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_start_addr", 32'(addr_o), 32'd4);
        check("busy_start_valid", 32'(valid_o), 32'd1);
        RST_N = 1'b0;
        step();
        check("midrst_addr", 32'(addr_o), 32'd0);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_zero", 32'(zero_cnt_o), 32'd0);
        RST_N = 1'b1;
        ready_i = 1'b0;
        step();

        // Single-address instance (FIRST=LAST=6)
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        check("one_fetch_valid", 32'(valid6), 32'd0);
        step();
        check("one_emit_valid", 32'(valid6), 32'd1);
        check("one_emit_data", 32'(data6), 32'd0);
        check("one_emit_addr", 32'(addr6), 32'd6);
        step();
        check("one_done", 32'(done6), 32'd1);
        check("one_zero", 32'(zero6), 32'd1);
        $display("txn single addr=%0d zero_cnt=%0d", addr6, zero6);
        step();
`ifdef MEM2_SEQ_REPEAT_EN
        check("one_repeat_busy", 32'(busy6), 32'd1);
        abort6 = 1'b1;
        step();
        abort6 = 1'b0;
`else
        check("one_idle_busy", 32'(busy6), 32'd0);
`endif

        // Zero counter saturation (2-bit counter, 21 zero bits)
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n = 0;
        while (!done_s && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("sat_done_timeout", 32'd0, 32'd1);
        check("sat_zero_cnt", 32'(zero_s), 32'd3);
        check("sat_addr", 32'(addr_s), 32'(LAST));
        $display("txn saturate zero_cnt=%0d", zero_s);
        abort_s = 1'b1;
        step();
        abort_s = 1'b0;

        // Randomized tables with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int a = FIRST; a <= LAST; a++) tbl[a] = 1'($urandom_range(1));
            play(60, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem2_seq_reader.md
Name: mem2_seq_reader

Overview:
Sequencer that reads the RST pattern table (the mem2 ROM) and plays it out as a handshaked serial bit stream. It walks the table address range FIRST_ADDR..LAST_ADDR and presents each address on addr_o. One cycle later it captures the table's combinational rst_bit_i. It emits that bit on a valid/ready interface to the downstream Moore-machine stimulus path, and reports a zero-bit count and completion.

Parameters:
ADDR_W, 10, width of addr_o; zero-extended to the table's address input at integration
FIRST_ADDR, 1, first table address read after start
LAST_ADDR, 21, last table address read; must be >= FIRST_ADDR
CNT_W, 5, width of zero_cnt_o; saturates at all-ones

Ports:
CLK  input  1  single clock, all logic rising-edge
RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
start_i  input  1  one-cycle request to play the table; honoured only in IDLE
abort_i  input  1  abandon current playback; highest priority after reset
addr_o  output  ADDR_W  table address driven to the ROM
rst_bit_i  input  1  ROM data for addr_o, combinational from the table
data_o  output  1  emitted pattern bit
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o when valid_o&&ready_i
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse after last bit is accepted
zero_cnt_o  output  CNT_W  number of 0 bits accepted in the current/last playback

Behaviour:
- Reset (RST_N=0 at edge), including mid-playback: state=IDLE, addr_o=0, data_o=0, valid_o=0, busy_o=0, done_o=0, zero_cnt_o=0.
- States: IDLE, FETCH, EMIT, DONE. All outputs are registered.
- IDLE: start_i=1 -> addr_o<=FIRST_ADDR, zero_cnt_o<=0, go FETCH. start_i is ignored in every other state.
- FETCH: exactly one cycle of ROM settling. At the end of the cycle, data_o<=rst_bit_i and valid_o<=1, go EMIT.
- EMIT: data_o and valid_o are held stable until the handshake; valid_o never drops without a handshake except on abort or reset.
- On handshake (valid_o&&ready_i) in EMIT:
  - valid_o<=0.
  - If data_o==0, zero_cnt_o increments, saturating at 2^CNT_W-1.
  - If addr_o==LAST_ADDR, go DONE.
  - Otherwise addr_o<=addr_o+1 and go FETCH. No wrap: addr_o never exceeds LAST_ADDR.
- DONE: done_o=1 for exactly this one cycle, then IDLE. addr_o holds LAST_ADDR, and zero_cnt_o holds until the next start.
- Throughput: with ready_i tied high, one bit every 2 cycles. A full default playback is start -> done_o in 2*(LAST_ADDR-FIRST_ADDR+1)+1 cycles.
- abort_i=1 in any state: next edge -> IDLE, valid_o=0, done_o=0. addr_o and zero_cnt_o keep their values.
  - abort_i coincident with a handshake: abort wins, and the bit is not counted.
  - abort_i coincident with start_i in IDLE: stay IDLE.
- busy_o is derived registered, equal to (state!=IDLE).

Optional Feature:
MEM2_SEQ_REPEAT_EN
- Defined: DONE goes to FETCH with addr_o<=FIRST_ADDR and zero_cnt_o<=0, still pulsing done_o, so playback loops continuously until abort_i or reset; busy_o stays 1.
- Undefined: DONE returns to IDLE as above.

Test Plan:
- Reset then start_i with default table, ready_i=1 -> accepted bits 0,1,1,1,1,0 then fifteen 1s; addr_o steps 1..21; zero_cnt_o=2; done_o pulses at cycle 43 after start; busy_o falls the cycle after.
- Backpressure: ready_i low for 5 cycles while EMIT at addr_o=6 -> data_o=0 and valid_o=1 held all 5 cycles; handshake counts one zero; addr_o advances to 7.
- abort_i at addr_o=10 during a handshake -> IDLE next edge, valid_o=0, zero_cnt_o stays 2, no done_o; a new start_i restarts at addr_o=1 with zero_cnt_o=0.
- RST_N=0 mid-playback at addr_o=4 -> all outputs zero next edge; start_i pulsed in a busy state is ignored.
- FIRST_ADDR=LAST_ADDR=6 -> single bit 0 emitted, zero_cnt_o=1, done_o 3 cycles after start.
- With MEM2_SEQ_REPEAT_EN defined -> done_o every 43 cycles; address wraps 21->1; zero_cnt_o cleared to 0 each loop and reaches 2 before each done_o.
